// File: rtl/gxb_rx_reset_if.sv
// Receive-side reset handshake between the per-channel reset controller and the transceiver.
// The master modport is the controller; the slave modport is the transceiver channel side.
interface gxb_rx_reset_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] rx_analogreset;
  logic [CHANNELS-1:0] rx_digitalreset;
  logic [CHANNELS-1:0] rx_ready;
  logic [CHANNELS-1:0] rx_is_lockedtodata;
  logic [CHANNELS-1:0] rx_cal_busy;

  modport master (
    output rx_analogreset,
    output rx_digitalreset,
    output rx_ready,
    input  rx_is_lockedtodata,
    input  rx_cal_busy
  );

  modport slave (
    input  rx_analogreset,
    input  rx_digitalreset,
    input  rx_ready,
    output rx_is_lockedtodata,
    output rx_cal_busy
  );
endinterface

// File: rtl/gxb_rx_reset.sv
// Per-channel transceiver receive reset sequencer: analog reset hold, lock-to-data
// qualification, then PCS release. Every channel runs its own independent FSM.
module gxb_rx_reset #(
  parameter int CHANNELS = 4,
  parameter int T_ANALOG = 40,
  parameter int T_LTD    = 400
) (
  input  logic           clock,
  input  logic           reset,
  gxb_rx_reset_if.master rx
);

  typedef enum logic [1:0] {
    ANALOG   = 2'd0,
    WAIT_LTD = 2'd1,
    READY    = 2'd2
  } state_t;

  localparam logic [15:0] ANA_LAST = 16'(T_ANALOG - 1);
  localparam logic [15:0] LTD_LAST = 16'(T_LTD - 1);

  logic [CHANNELS-1:0] ltd_p0, ltd_s;
  logic [CHANNELS-1:0] cal_p0, cal_s;
  logic                vld_p0, vld_p1;

  logic [CHANNELS-1:0] analog_q, digital_q, ready_q;

  // Stage p0 -> s: two-flop synchronizers. vld_p1 marks when the synchronized
  // values reflect post-reset input, so the FSMs hold off until then.
  always_ff @(posedge clock) begin
    if (reset) begin
      ltd_p0 <= '0;
      ltd_s  <= '0;
      cal_p0 <= '0;
      cal_s  <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      ltd_p0 <= rx.rx_is_lockedtodata;
      ltd_s  <= ltd_p0;
      cal_p0 <= rx.rx_cal_busy;
      cal_s  <= cal_p0;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t      st;
    logic [15:0] cnt;

    always_ff @(posedge clock) begin
      if (reset) begin
        st  <= ANALOG;
        cnt <= '0;
      end else if (vld_p1) begin
        case (st)
          ANALOG: begin
            if (cal_s[g]) begin
              cnt <= '0;
            end else if (cnt == ANA_LAST) begin
              st  <= WAIT_LTD;
              cnt <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          WAIT_LTD: begin
            // Calibration outranks any lock-driven move.
            if (cal_s[g]) begin
              st  <= ANALOG;
              cnt <= '0;
            end else if (!ltd_s[g]) begin
              cnt <= '0;
            end else if (cnt == LTD_LAST) begin
              st  <= READY;
              cnt <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          READY: begin
            if (cal_s[g]) begin
              st  <= ANALOG;
              cnt <= '0;
            end else if (!ltd_s[g]) begin
              st  <= WAIT_LTD;
              cnt <= '0;
            end
          end
          default: begin
            st  <= ANALOG;
            cnt <= '0;
          end
        endcase
      end
    end

    assign analog_q[g]  = (st == ANALOG);
    assign digital_q[g] = (st != READY);
    assign ready_q[g]   = (st == READY);
  end

  assign rx.rx_analogreset  = analog_q;
  assign rx.rx_digitalreset = digital_q;
  assign rx.rx_ready        = ready_q;

endmodule

// File: tb/tb_gxb_rx_reset.sv
// Directed bench for gxb_rx_reset (T_ANALOG=4, T_LTD=8): stimulus pushes hand-computed
// per-cycle outputs into a queue, a monitor pops and compares one entry each cycle.
module tb_gxb_rx_reset;

  localparam int CH = 4;

  typedef struct packed {
    logic [3:0] ar;
    logic [3:0] dr;
    logic [3:0] rdy;
    logic [7:0] ph;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gxb_rx_reset_if #(.CHANNELS(CH)) rx ();

  gxb_rx_reset #(
    .CHANNELS(CH),
    .T_ANALOG(4),
    .T_LTD   (8)
  ) dut (
    .clock(clk),
    .reset(rst),
    .rx   (rx)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Per-phase expected output patterns
  localparam logic [3:0] ALL = 4'b1111;
  localparam logic [3:0] NON = 4'b0000;

  // Inputs set 2 time units after edge k-1 are sampled at edge k; the pushed
  // entry is the output expected right after edge k.
  task automatic cyc(input int n, input logic r, input logic [3:0] ltd, input logic [3:0] cal,
                     input logic [3:0] ar, input logic [3:0] dr, input logic [3:0] rdy,
                     input logic [7:0] ph);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      rst = r;
      rx.rx_is_lockedtodata = ltd;
      rx.rx_cal_busy        = cal;
      e.ar  = ar;
      e.dr  = dr;
      e.rdy = rdy;
      e.ph  = ph;
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cycle = cycle + 1;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks = checks + 1;
      if (rx.rx_analogreset !== e.ar || rx.rx_digitalreset !== e.dr || rx.rx_ready !== e.rdy) begin
        errors = errors + 1;
        $display("FAIL phase%0d cyc%0d got ar=%b dr=%b rdy=%b want ar=%b dr=%b rdy=%b",
                 e.ph, cycle, rx.rx_analogreset, rx.rx_digitalreset, rx.rx_ready,
                 e.ar, e.dr, e.rdy);
      end
    end
  end

  // Nominal bring-up from a reset whose last asserted edge is edge 0.
  task automatic bringup(input logic [7:0] ph);
    cyc(5, 1'b0, ALL, NON, ALL, ALL, NON, ph);
    cyc(8, 1'b0, ALL, NON, NON, ALL, NON, ph);
    cyc(3, 1'b0, ALL, NON, NON, NON, ALL, ph);
  endtask

  initial begin
    rst = 1'b1;
    rx.rx_is_lockedtodata = ALL;
    rx.rx_cal_busy        = NON;

    // Reset state
    cyc(3, 1'b1, ALL, NON, ALL, ALL, NON, 8'd1);
    // Bring-up: analog high through edge 5, ready at edge 14
    bringup(8'd2);

    // Lock glitch on channel 2
    cyc(1, 1'b0, 4'b1011, NON, NON, NON, ALL, 8'd3);
    cyc(1, 1'b0, ALL,     NON, NON, NON, ALL, 8'd3);
    cyc(8, 1'b0, ALL,     NON, NON, 4'b0100, 4'b1011, 8'd3);
    cyc(3, 1'b0, ALL,     NON, NON, NON, ALL, 8'd3);

    // Calibration on channel 1 held 20 cycles
    cyc(2,  1'b0, ALL, 4'b0010, NON,     NON,     ALL,     8'd4);
    cyc(18, 1'b0, ALL, 4'b0010, 4'b0010, 4'b0010, 4'b1101, 8'd4);
    cyc(5,  1'b0, ALL, NON,     4'b0010, 4'b0010, 4'b1101, 8'd4);
    cyc(8,  1'b0, ALL, NON,     NON,     4'b0010, 4'b1101, 8'd4);
    cyc(3,  1'b0, ALL, NON,     NON,     NON,     ALL,     8'd4);

    // Calibration and lock loss on channel 0 in the same cycle
    cyc(1, 1'b0, 4'b1110, 4'b0001, NON, NON, ALL, 8'd5);
    cyc(1, 1'b0, ALL,     NON,     NON, NON, ALL, 8'd5);
    cyc(4, 1'b0, ALL, NON, 4'b0001, 4'b0001, 4'b1110, 8'd5);
    cyc(8, 1'b0, ALL, NON, NON,     4'b0001, 4'b1110, 8'd5);
    cyc(3, 1'b0, ALL, NON, NON,     NON,     ALL,     8'd5);

    // Partial lock on channel 3: 7 high, 1 low, then high
    cyc(2, 1'b0, 4'b0111, NON, NON, NON,     ALL,     8'd6);
    cyc(1, 1'b0, 4'b0111, NON, NON, 4'b1000, 4'b0111, 8'd6);
    cyc(7, 1'b0, ALL,     NON, NON, 4'b1000, 4'b0111, 8'd6);
    cyc(1, 1'b0, 4'b0111, NON, NON, 4'b1000, 4'b0111, 8'd6);
    cyc(9, 1'b0, ALL,     NON, NON, 4'b1000, 4'b0111, 8'd6);
    cyc(3, 1'b0, ALL,     NON, NON, NON,     ALL,     8'd6);

    // One-cycle reset pulse while all READY, then full bring-up again
    cyc(1, 1'b1, ALL, NON, ALL, ALL, NON, 8'd7);
    bringup(8'd8);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
